// File: rtl/brq_dmem_pkg.sv
// Shared types for the data-memory bus interface: FSM states, access codes
// and the byte-strobe width.
package brq_dmem_pkg;

  localparam int BeWidth = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dmem_state_e;

  typedef enum logic [2:0] {
    LB0     = 3'b000,
    LB1     = 3'b001,
    LB2     = 3'b010,
    LB3     = 3'b011,
    LH_LO   = 3'b100,
    LH_HI   = 3'b101,
    LW      = 3'b110,
    INVALID = 3'b111
  } dmem_code_e;

endpackage

// File: rtl/brq_dmem_lane_steer.sv
// Combinational lane steering: turns an access code and right-aligned store
// data into bus byte strobes and replicated write data.
module brq_dmem_lane_steer
  import brq_dmem_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [2:0]           code,
  input  logic [DataWidth-1:0] data,
  output logic [BeWidth-1:0]   be,
  output logic [DataWidth-1:0] wdata,
  output logic                 invalid
);

  // Narrow stores replicate their bytes across every lane so the slave can
  // pick whichever lane the strobes select.
  always_comb begin
    be      = '0;
    wdata   = '0;
    invalid = 1'b0;
    case (dmem_code_e'(code))
      LB0, LB1, LB2, LB3: begin
        be    = 4'b0001 << code[1:0];
        wdata = {4{data[7:0]}};
      end
      LH_LO: begin
        be    = 4'b0011;
        wdata = {2{data[15:0]}};
      end
      LH_HI: begin
        be    = 4'b1100;
        wdata = {2{data[15:0]}};
      end
      LW: begin
        be    = 4'b1111;
        wdata = data;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/brq_dmem_if.sv
// Data-memory bus interface: issues one req/gnt/rvalid transaction per
// load/store, stalls the pipeline until it completes, and faults on timeout.
module brq_dmem_if
  import brq_dmem_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 15,
  parameter int TimeoutCycles = 255
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst_n,
  input  logic                 ldst_req_valid,
  input  logic                 ldst_we,
  input  logic [2:0]           ldst_byte_en,
  input  logic [AddrWidth-1:0] ldst_mem_addr,
  input  logic [DataWidth-1:0] ldst_store_data,
  output logic [DataWidth-1:0] ldst_load_data_in,
  output logic                 dmem_stall,
  output logic                 dmem_done,
  output logic                 dmem_fault,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [BeWidth-1:0]   dmem_be,
  output logic [AddrWidth-1:0] dmem_addr,
  output logic [DataWidth-1:0] dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [DataWidth-1:0] dmem_rdata,
  input  logic                 dmem_err
);

  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  dmem_state_e state_q, state_d;
  logic [CntWidth-1:0]  cnt_q;
  logic [BeWidth-1:0]   steer_be;
  logic [DataWidth-1:0] steer_wdata;
  logic                 steer_invalid;
  logic                 accept, issue, complete, timeout;

  brq_dmem_lane_steer #(.DataWidth(DataWidth)) u_lane_steer (
    .code    (ldst_byte_en),
    .data    (ldst_store_data),
    .be      (steer_be),
    .wdata   (steer_wdata),
    .invalid (steer_invalid)
  );

  // The done/fault cycle still carries the finished instruction, so it must
  // not be accepted again.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    issue    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = ldst_req_valid && !dmem_done && !dmem_fault;
        issue  = accept && !steer_invalid;
        if (issue) state_d = REQ;
      end
      REQ: begin
        if (dmem_gnt && dmem_rvalid) complete = 1'b1;
        else if (cnt_q == CntLast)   timeout  = 1'b1;
        else if (dmem_gnt)           state_d  = WAIT;
      end
      WAIT: begin
        if (dmem_rvalid)           complete = 1'b1;
        else if (cnt_q == CntLast) timeout  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (complete || timeout) state_d = IDLE;
  end

  assign dmem_stall = accept || (state_q == REQ) || (state_q == WAIT);

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n)            cnt_q <= '0;
    else if (issue)            cnt_q <= '0;
    else if (state_q != IDLE)  cnt_q <= cnt_q + 1'b1;
  end

  // Bus fields are captured once at issue and held until the slave grants.
  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_be           <= '0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      dmem_done         <= 1'b0;
      dmem_fault        <= 1'b0;
      ldst_load_data_in <= '0;
    end else begin
      dmem_done  <= complete && !dmem_err;
      dmem_fault <= (complete && dmem_err) || timeout || (accept && steer_invalid);
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ldst_we;
        dmem_be    <= steer_be;
        dmem_addr  <= ldst_mem_addr;
        dmem_wdata <= steer_wdata;
      end else if (((state_q == REQ) && dmem_gnt) || timeout) begin
        dmem_req <= 1'b0;
      end
      if ((complete || timeout) && !dmem_we)
        ldst_load_data_in <= (complete && !dmem_err) ? dmem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_brq_dmem_if.sv
// Directed bench for brq_dmem_if: one request per test, bus slave driven
// cycle by cycle, outputs sampled one time unit after each falling edge.
module tb_brq_dmem_if;

  logic        brq_clk;
  logic        brq_rst_n;
  logic        ldst_req_valid;
  logic        ldst_we;
  logic [2:0]  ldst_byte_en;
  logic [14:0] ldst_mem_addr;
  logic [31:0] ldst_store_data;
  logic [31:0] ldst_load_data_in;
  logic        dmem_stall, dmem_done, dmem_fault;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [14:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_rdata;

  int checks   = 0;
  int failures = 0;

  brq_dmem_if #(.DataWidth(32), .AddrWidth(15), .TimeoutCycles(4)) dut (
    .brq_clk           (brq_clk),
    .brq_rst_n         (brq_rst_n),
    .ldst_req_valid    (ldst_req_valid),
    .ldst_we           (ldst_we),
    .ldst_byte_en      (ldst_byte_en),
    .ldst_mem_addr     (ldst_mem_addr),
    .ldst_store_data   (ldst_store_data),
    .ldst_load_data_in (ldst_load_data_in),
    .dmem_stall        (dmem_stall),
    .dmem_done         (dmem_done),
    .dmem_fault        (dmem_fault),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_be           (dmem_be),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_gnt          (dmem_gnt),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .dmem_err          (dmem_err)
  );

  initial begin
    brq_clk = 1'b0;
    forever #5 brq_clk = ~brq_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of pipeline-valid and slave response, then settles.
  task automatic applyStimulus(input logic valid, input logic gnt, input logic rvalid,
                               input logic [31:0] rdata, input logic err);
    @(negedge brq_clk);
    ldst_req_valid = valid;
    dmem_gnt       = gnt;
    dmem_rvalid    = rvalid;
    dmem_rdata     = rdata;
    dmem_err       = err;
    #1;
  endtask

  task automatic setRequest(input logic we, input logic [2:0] code, input logic [14:0] addr,
                            input logic [31:0] data);
    ldst_we         = we;
    ldst_byte_en    = code;
    ldst_mem_addr   = addr;
    ldst_store_data = data;
  endtask

  initial begin
    brq_rst_n      = 1'b0;
    ldst_req_valid = 1'b0;
    dmem_gnt       = 1'b0;
    dmem_rvalid    = 1'b0;
    dmem_rdata     = '0;
    dmem_err       = 1'b0;
    setRequest(1'b0, 3'b000, 15'h0, 32'h0);

    @(negedge brq_clk);
    #1;
    checkOutput("rst_req",   32'(dmem_req), 32'd0);
    checkOutput("rst_be",    32'(dmem_be), 32'd0);
    checkOutput("rst_addr",  32'(dmem_addr), 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_load",  ldst_load_data_in, 32'd0);
    checkOutput("rst_done",  32'(dmem_done), 32'd0);
    checkOutput("rst_fault", 32'(dmem_fault), 32'd0);
    checkOutput("rst_stall", 32'(dmem_stall), 32'd0);
    brq_rst_n = 1'b1;

    $display("[TB] store word, zero-wait slave");
    setRequest(1'b1, 3'b110, 15'h0040, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sw_c0_stall", 32'(dmem_stall), 32'd1);
    checkOutput("sw_c0_req",   32'(dmem_req), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    checkOutput("sw_c1_req",   32'(dmem_req), 32'd1);
    checkOutput("sw_c1_we",    32'(dmem_we), 32'd1);
    checkOutput("sw_c1_be",    32'(dmem_be), 32'hF);
    checkOutput("sw_c1_addr",  32'(dmem_addr), 32'h40);
    checkOutput("sw_c1_wdata", dmem_wdata, 32'hDEADBEEF);
    checkOutput("sw_c1_stall", 32'(dmem_stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sw_c2_done",  32'(dmem_done), 32'd1);
    checkOutput("sw_c2_stall", 32'(dmem_stall), 32'd0);
    checkOutput("sw_c2_req",   32'(dmem_req), 32'd0);
    checkOutput("sw_c2_load",  ldst_load_data_in, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sw_c3_done",  32'(dmem_done), 32'd0);
    checkOutput("sw_c3_req",   32'(dmem_req), 32'd0);

    $display("[TB] load byte lane 2, three wait cycles");
    setRequest(1'b0, 3'b010, 15'h0123, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lb_c0_stall", 32'(dmem_stall), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("lb_c1_req",   32'(dmem_req), 32'd1);
    checkOutput("lb_c1_be",    32'(dmem_be), 32'h4);
    checkOutput("lb_c1_we",    32'(dmem_we), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lb_c2_req",   32'(dmem_req), 32'd0);
    checkOutput("lb_c2_stall", 32'(dmem_stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lb_c3_stall", 32'(dmem_stall), 32'd1);
    checkOutput("lb_c3_done",  32'(dmem_done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h11223344, 1'b0);
    checkOutput("lb_c4_stall", 32'(dmem_stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lb_c5_done",  32'(dmem_done), 32'd1);
    checkOutput("lb_c5_fault", 32'(dmem_fault), 32'd0);
    checkOutput("lb_c5_load",  ldst_load_data_in, 32'h11223344);
    checkOutput("lb_c5_stall", 32'(dmem_stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lb_c6_done",  32'(dmem_done), 32'd0);

    $display("[TB] store half upper, grant delayed two cycles");
    setRequest(1'b1, 3'b101, 15'h07FF, 32'h0000ABCD);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, (c == 3), (c == 3), 32'h0, 1'b0);
      checkOutput($sformatf("sh_c%0d_req", c),   32'(dmem_req), 32'd1);
      checkOutput($sformatf("sh_c%0d_be", c),    32'(dmem_be), 32'hC);
      checkOutput($sformatf("sh_c%0d_addr", c),  32'(dmem_addr), 32'h7FF);
      checkOutput($sformatf("sh_c%0d_wdata", c), dmem_wdata, 32'hABCDABCD);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sh_c4_done",  32'(dmem_done), 32'd1);
    checkOutput("sh_c4_load",  ldst_load_data_in, 32'h11223344);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("[TB] invalid access code");
    setRequest(1'b0, 3'b111, 15'h0010, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("inv_c0_stall", 32'(dmem_stall), 32'd1);
    checkOutput("inv_c0_req",   32'(dmem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("inv_c1_fault", 32'(dmem_fault), 32'd1);
    checkOutput("inv_c1_req",   32'(dmem_req), 32'd0);
    checkOutput("inv_c1_stall", 32'(dmem_stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("inv_c2_fault", 32'(dmem_fault), 32'd0);
    checkOutput("inv_c2_req",   32'(dmem_req), 32'd0);

    $display("[TB] load with bus error");
    setRequest(1'b0, 3'b110, 15'h0030, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
    checkOutput("err_c1_req",   32'(dmem_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("err_c2_fault", 32'(dmem_fault), 32'd1);
    checkOutput("err_c2_done",  32'(dmem_done), 32'd0);
    checkOutput("err_c2_load",  ldst_load_data_in, 32'd0);
    checkOutput("err_c2_stall", 32'(dmem_stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("err_c3_fault", 32'(dmem_fault), 32'd0);

    $display("[TB] reset during wait, then back-to-back requests");
    setRequest(1'b0, 3'b000, 15'h0005, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rw_wait_stall", 32'(dmem_stall), 32'd1);
    brq_rst_n = 1'b0;
    #1;
    checkOutput("rw_rst_stall", 32'(dmem_stall), 32'd0);
    checkOutput("rw_rst_req",   32'(dmem_req), 32'd0);
    checkOutput("rw_rst_be",    32'(dmem_be), 32'd0);
    #1;
    brq_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h99999999, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rw_stale_done",  32'(dmem_done), 32'd0);
    checkOutput("rw_stale_fault", 32'(dmem_fault), 32'd0);
    checkOutput("rw_stale_load",  ldst_load_data_in, 32'd0);
    setRequest(1'b0, 3'b011, 15'h0022, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
    checkOutput("bb_a_be",     32'(dmem_be), 32'h8);
    checkOutput("bb_a_req",    32'(dmem_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bb_a_done",   32'(dmem_done), 32'd1);
    checkOutput("bb_a_load",   ldst_load_data_in, 32'hCAFEF00D);
    checkOutput("bb_a_noreq",  32'(dmem_req), 32'd0);
    checkOutput("bb_a_stall",  32'(dmem_stall), 32'd0);
    setRequest(1'b1, 3'b001, 15'h0023, 32'h0000005A);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bb_b_c0_stall", 32'(dmem_stall), 32'd1);
    checkOutput("bb_b_c0_done",  32'(dmem_done), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    checkOutput("bb_b_be",     32'(dmem_be), 32'h2);
    checkOutput("bb_b_wdata",  dmem_wdata, 32'h5A5A5A5A);
    checkOutput("bb_b_addr",   32'(dmem_addr), 32'h23);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bb_b_done",   32'(dmem_done), 32'd1);
    checkOutput("bb_b_load",   ldst_load_data_in, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bb_b_once",   32'(dmem_done), 32'd0);
    checkOutput("bb_b_noreq",  32'(dmem_req), 32'd0);

    $display("[TB] timeout with a silent slave");
    setRequest(1'b0, 3'b110, 15'h0010, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("to_c%0d_req", c),   32'(dmem_req), 32'd1);
      checkOutput($sformatf("to_c%0d_fault", c), 32'(dmem_fault), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("to_c5_req",   32'(dmem_req), 32'd0);
    checkOutput("to_c5_fault", 32'(dmem_fault), 32'd1);
    checkOutput("to_c5_load",  ldst_load_data_in, 32'd0);
    checkOutput("to_c5_stall", 32'(dmem_stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    checkOutput("to_c6_fault", 32'(dmem_fault), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("to_c7_done",  32'(dmem_done), 32'd0);
    checkOutput("to_c7_fault", 32'(dmem_fault), 32'd0);
    checkOutput("to_c7_load",  ldst_load_data_in, 32'd0);
    checkOutput("to_c7_req",   32'(dmem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
